// File: rtl/cpu_seq_pkg.sv
// Shared types and phase-index helpers for the CPU phase sequencer and its decoder.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_SEL,
    ST_LOAD,
    ST_PAD,
    ST_COMMIT
  } seq_state_e;

  localparam int unsigned PH_FETCH  = 0;
  localparam int unsigned PH_DECODE = 1;

  function automatic int unsigned num_phases(input int unsigned ns, input int unsigned pads);
    return 3 + 2 * ns + pads;
  endfunction

  function automatic int unsigned ph_sel(input int unsigned k);
    return 2 + 2 * k;
  endfunction

  function automatic int unsigned ph_load(input int unsigned k);
    return 3 + 2 * k;
  endfunction

  function automatic int unsigned ph_pad(input int unsigned ns, input int unsigned p);
    return 2 + 2 * ns + p;
  endfunction

  function automatic int unsigned ph_commit(input int unsigned ns, input int unsigned pads);
    return num_phases(ns, pads) - 1;
  endfunction

endpackage

// File: rtl/cpu_phase_decode.sv
// Maps sequencer state, slot and latched slot count onto the one-hot phase vector and strobes.
module cpu_phase_decode
  import cpu_seq_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = 3,
  parameter int unsigned PAD_PHASES = 3,
  parameter int unsigned SLOT_W     = 2,
  parameter int unsigned PAD_W      = 2,
  localparam int unsigned PH_W      = num_phases(NUM_SLOTS, PAD_PHASES)
) (
  input  seq_state_e        state,
  input  logic [SLOT_W-1:0] slot,
  input  logic [PAD_W-1:0]  pad,
  input  logic [SLOT_W-1:0] n,
  input  logic              stall,
  output logic [PH_W-1:0]   phase,
  output logic              fetch_en,
  output logic              decode_en,
  output logic              sel_en,
  output logic              load_en,
  output logic              commit_en,
  output logic [SLOT_W-1:0] slot_idx,
  output logic              busy
);

  logic slot_used;
  assign slot_used = (slot < n);

  // A stalled phase shows nothing; unused slots in fixed-length mode stay dark.
  always_comb begin
    phase   = '0;
    sel_en  = 1'b0;
    load_en = 1'b0;
    if (!stall) begin
      unique case (state)
        ST_FETCH:  phase = PH_W'(1) << PH_FETCH;
        ST_DECODE: phase = PH_W'(1) << PH_DECODE;
        ST_SEL: if (slot_used) begin
          phase  = PH_W'(1) << ph_sel(32'(slot));
          sel_en = 1'b1;
        end
        ST_LOAD: if (slot_used) begin
          phase   = PH_W'(1) << ph_load(32'(slot));
          load_en = 1'b1;
        end
        ST_PAD:    phase = PH_W'(1) << ph_pad(NUM_SLOTS, 32'(pad));
        ST_COMMIT: phase = PH_W'(1) << ph_commit(NUM_SLOTS, PAD_PHASES);
        default:   phase = '0;
      endcase
    end
  end

  assign fetch_en  = phase[PH_FETCH];
  assign decode_en = phase[PH_DECODE];
  assign commit_en = phase[PH_W-1];
  assign slot_idx  = (sel_en || load_en) ? slot : '0;
  assign busy      = (state != ST_IDLE);

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Parametrised CPU phase sequencer: fetch, decode, select/load slot pairs, pads, commit.
module cpu_phase_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = 3,
  parameter int unsigned PAD_PHASES = 3,
  parameter int unsigned FIXED_LEN  = 1,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned NUM_PHASES = num_phases(NUM_SLOTS, PAD_PHASES),
  localparam int unsigned SLOT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  halt_req,
  input  logic                  stall,
  input  logic [SLOT_W-1:0]     num_slots,
  output logic [NUM_PHASES-1:0] phase,
  output logic                  fetch_en,
  output logic                  decode_en,
  output logic                  sel_en,
  output logic                  load_en,
  output logic                  commit_en,
  output logic [SLOT_W-1:0]     slot_idx,
  output logic                  busy,
  output logic [CNT_W-1:0]      instr_count
);

  localparam int unsigned PAD_W = (PAD_PHASES > 1) ? $clog2(PAD_PHASES) : 1;

  seq_state_e        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [PAD_W-1:0]  pad_q, pad_d;
  logic [SLOT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SLOT_W-1:0] n_in;
  logic              last_slot;

  assign n_in = (num_slots > SLOT_W'(NUM_SLOTS)) ? SLOT_W'(NUM_SLOTS) : num_slots;

  // Fixed-length mode walks every slot; variable mode stops after the last used one.
  assign last_slot = (FIXED_LEN != 0) ? (slot_q == SLOT_W'(NUM_SLOTS - 1))
                                      : ((slot_q + SLOT_W'(1)) >= n_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      pad_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      pad_q   <= pad_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every non-idle state advances only on an unstalled cycle; halt is honoured at commit only.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    pad_d   = pad_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE:  if (run && !halt_req) state_d = ST_FETCH;
      ST_FETCH: if (!stall) state_d = ST_DECODE;
      ST_DECODE: if (!stall) begin
        n_d     = n_in;
        slot_d  = '0;
        state_d = ((FIXED_LEN != 0) || (n_in != '0)) ? ST_SEL : ST_COMMIT;
      end
      ST_SEL: if (!stall) state_d = ST_LOAD;
      ST_LOAD: if (!stall) begin
        if (!last_slot) begin
          slot_d  = slot_q + SLOT_W'(1);
          state_d = ST_SEL;
        end else begin
          slot_d  = '0;
          pad_d   = '0;
          state_d = ((FIXED_LEN != 0) && (PAD_PHASES != 0)) ? ST_PAD : ST_COMMIT;
        end
      end
      ST_PAD: if (!stall) begin
        if (pad_q == PAD_W'(PAD_PHASES - 1)) begin
          pad_d   = '0;
          state_d = ST_COMMIT;
        end else begin
          pad_d = pad_q + PAD_W'(1);
        end
      end
      ST_COMMIT: if (!stall) begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (run && !halt_req) ? ST_FETCH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  cpu_phase_decode #(
    .NUM_SLOTS (NUM_SLOTS),
    .PAD_PHASES(PAD_PHASES),
    .SLOT_W    (SLOT_W),
    .PAD_W     (PAD_W)
  ) u_decode (
    .state    (state_q),
    .slot     (slot_q),
    .pad      (pad_q),
    .n        (n_q),
    .stall    (stall),
    .phase    (phase),
    .fetch_en (fetch_en),
    .decode_en(decode_en),
    .sel_en   (sel_en),
    .load_en  (load_en),
    .commit_en(commit_en),
    .slot_idx (slot_idx),
    .busy     (busy)
  );

  assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Scoreboard bench for cpu_phase_sequencer in fixed-length (index 0) and variable-length (index 1) modes.
module tb_cpu_phase_sequencer;

  typedef struct packed {
    logic [11:0] ph;
    logic [1:0]  slot;
  } exp_t;

  localparam logic [11:0] SEL_MASK  = 12'h054;
  localparam logic [11:0] LOAD_MASK = 12'h0A8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ns;
  logic        run_f, halt_f, stall_f, run_v, halt_v, stall_v;
  logic [11:0] ph_f, ph_v;
  logic        fe_f, de_f, se_f, le_f, ce_f, bz_f;
  logic        fe_v, de_v, se_v, le_v, ce_v, bz_v;
  logic [1:0]  si_f, si_v;
  logic [31:0] cnt_f, cnt_v;

  exp_t        q [2][$];
  logic [31:0] mcnt [2];
  int          fetches [2];
  bit          mon_en;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  cpu_phase_sequencer #(.FIXED_LEN(1)) u_fix (
    .clk(clk), .reset(reset), .run(run_f), .halt_req(halt_f), .stall(stall_f),
    .num_slots(ns), .phase(ph_f), .fetch_en(fe_f), .decode_en(de_f), .sel_en(se_f),
    .load_en(le_f), .commit_en(ce_f), .slot_idx(si_f), .busy(bz_f), .instr_count(cnt_f)
  );

  cpu_phase_sequencer #(.FIXED_LEN(0)) u_var (
    .clk(clk), .reset(reset), .run(run_v), .halt_req(halt_v), .stall(stall_v),
    .num_slots(ns), .phase(ph_v), .fetch_en(fe_v), .decode_en(de_v), .sel_en(se_v),
    .load_en(le_v), .commit_en(ce_v), .slot_idx(si_v), .busy(bz_v), .instr_count(cnt_v)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int b, input int s);
    exp_t e;
    e.ph   = (b < 0) ? 12'd0 : (12'(1) << b);
    e.slot = 2'(s);
    return e;
  endfunction

  // Expected visible phase per unstalled busy cycle of one instruction.
  task automatic push_instr(input int w, input int n);
    int slots;
    slots = (w == 0) ? 3 : n;
    q[w].push_back(mk(0, 0));
    q[w].push_back(mk(1, 0));
    for (int k = 0; k < slots; k++) begin
      if (k < n) begin
        q[w].push_back(mk(2 + 2 * k, k));
        q[w].push_back(mk(3 + 2 * k, k));
      end else begin
        q[w].push_back(mk(-1, 0));
        q[w].push_back(mk(-1, 0));
      end
    end
    if (w == 0) for (int p = 0; p < 3; p++) q[w].push_back(mk(8 + p, 0));
    q[w].push_back(mk(11, 0));
  endtask

  task automatic check_dut(input int w, input logic [11:0] ph, input logic fe, input logic de,
                           input logic se, input logic le, input logic ce, input logic [1:0] si,
                           input logic bz, input logic [31:0] cnt, input logic st);
    exp_t  e;
    string tag;
    tag = (w == 0) ? "fix" : "var";
    chk({tag, ".instr_count"}, 64'(cnt), 64'(mcnt[w]));
    if (bz && !st) begin
      if (q[w].size() == 0) begin
        chk({tag, ".busy_unexpected"}, 64'(bz), 64'(0));
      end else begin
        e = q[w].pop_front();
        chk({tag, ".phase"}, 64'(ph), 64'(e.ph));
        chk({tag, ".slot_idx"}, 64'(si), 64'(e.slot));
        chk({tag, ".strobes"}, 64'({fe, de, se, le, ce}),
            64'({e.ph[0], e.ph[1], |(e.ph & SEL_MASK), |(e.ph & LOAD_MASK), e.ph[11]}));
        if (e.ph[11]) mcnt[w] = mcnt[w] + 32'd1;
        if (e.ph[0]) fetches[w]++;
      end
    end else begin
      chk({tag, ".quiet"}, 64'({ph, fe, de, se, le, ce, si}), 64'(0));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_dut(0, ph_f, fe_f, de_f, se_f, le_f, ce_f, si_f, bz_f, cnt_f, stall_f);
      check_dut(1, ph_v, fe_v, de_v, se_v, le_v, ce_v, si_v, bz_v, cnt_v, stall_v);
    end
  end

  task automatic check_all_zero(input string name);
    chk({name, ".fix_out"}, 64'({ph_f, fe_f, de_f, se_f, le_f, ce_f, si_f, bz_f}), 64'(0));
    chk({name, ".fix_cnt"}, 64'(cnt_f), 64'(0));
    chk({name, ".var_out"}, 64'({ph_v, fe_v, de_v, se_v, le_v, ce_v, si_v, bz_v}), 64'(0));
    chk({name, ".var_cnt"}, 64'(cnt_v), 64'(0));
  endtask

  // Run m instructions with n slots on both DUTs; halt is raised once the m-th fetch has fired.
  task automatic episode(input int n, input int m, input int pct);
    bit done;
    ns = 2'(n);
    for (int k = 0; k < m; k++) begin
      push_instr(0, n);
      push_instr(1, n);
    end
    fetches[0] = 0;
    fetches[1] = 0;
    halt_f = 1'b0;
    halt_v = 1'b0;
    @(posedge clk); #1;
    run_f = 1'b1; run_v = 1'b1; stall_f = 1'b0; stall_v = 1'b0;
    @(posedge clk); #1;
    chk("fix.start_busy", 64'(bz_f), 64'(1));
    chk("var.start_busy", 64'(bz_v), 64'(1));
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      stall_f = ($urandom_range(99) < pct);
      stall_v = ($urandom_range(99) < pct);
      @(negedge clk); #1;
      halt_f = (fetches[0] >= m);
      halt_v = (fetches[1] >= m);
      done = halt_f && halt_v && !bz_f && !bz_v;
      @(posedge clk); #1;
    end
    chk("episode_done", 64'(done), 64'(1));
    stall_f = 1'b0; stall_v = 1'b0;
    run_f = 1'b0; run_v = 1'b0;
    halt_f = 1'b0; halt_v = 1'b0;
    chk("fix.queue_drained", 64'(q[0].size()), 64'(0));
    chk("var.queue_drained", 64'(q[1].size()), 64'(0));
    q[0].delete();
    q[1].delete();
  endtask

  // Asynchronous reset in the middle of LOAD2 on the fixed-length DUT.
  task automatic reset_mid_instr();
    bit found;
    ns = 2'd3;
    push_instr(0, 3);
    halt_f = 1'b0; stall_f = 1'b0;
    @(posedge clk); #1;
    run_f = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk); #1;
      found = se_f && (si_f == 2'd2);
    end
    chk("reset.reached_sel2", 64'(found), 64'(1));
    @(posedge clk); #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check_all_zero("async_reset");
    run_f = 1'b0;
    q[0].delete();
    q[1].delete();
    mcnt[0] = 32'd0;
    mcnt[1] = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    run_f = 1'b0; halt_f = 1'b0; stall_f = 1'b0;
    run_v = 1'b0; halt_v = 1'b0; stall_v = 1'b0;
    ns = 2'd0;
    mon_en = 1'b0;
    mcnt[0] = 32'd0; mcnt[1] = 32'd0;
    fetches[0] = 0; fetches[1] = 0;
    #1 reset = 1'b0;
    #2 check_all_zero("reset_state");
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;

    episode(3, 2, 0);
    episode(1, 1, 0);
    episode(0, 1, 0);
    episode(2, 2, 0);
    episode(3, 1, 60);
    for (int i = 0; i < 10; i++)
      episode(int'($urandom_range(3)), int'($urandom_range(3, 1)), 20 * int'($urandom_range(2)));

    reset_mid_instr();
    episode(2, 1, 30);

    // Counter wrap: preload the count register and retire one instruction.
    @(posedge clk); #1;
    force u_fix.cnt_q = 32'hFFFF_FFFF;
    force u_var.cnt_q = 32'hFFFF_FFFF;
    #1;
    release u_fix.cnt_q;
    release u_var.cnt_q;
    mcnt[0] = 32'hFFFF_FFFF;
    mcnt[1] = 32'hFFFF_FFFF;
    chk("fix.preload", 64'(cnt_f), 64'(32'hFFFF_FFFF));
    episode(1, 1, 0);
    chk("fix.wrap", 64'(cnt_f), 64'(0));
    chk("var.wrap", 64'(cnt_v), 64'(0));

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
